hub75_line_tx: RTL and testbench
================================

HUB75_LINE_TX -- requirements
Module: hub75_line_tx

Interface
REQ-001 SHALL have parameter hpixel_p, default 64, meaning display width in pixels.
REQ-002 SHALL have parameter vpixel_p, default 64, meaning display height in pixels.
REQ-003 SHALL have parameter bpp_p, default 8, meaning bits per colour channel.
REQ-004 SHALL have parameter clk_div_wd_p, default 8, meaning clock-divider width.
REQ-005 SHALL derive localparams: frame_size_p = hpixel_p*vpixel_p; addr_width_p = clog2(frame_size_p); pix_bit_width_p = clog2(bpp_p); two segments fixed.
REQ-006 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-007 SHALL have ports: i_clk_div in clk_div_wd_p, divider value D; i_tx_start in 1, line start pulse; i_init_addr in addr_width_p, first pixel address of the upper-segment row; i_pix_bit in pix_bit_width_p, bit plane to send.
REQ-008 SHALL have ports: i_blanking in 1, panel blanked; i_timer_en in 1, display timer running; o_tx_ready out 1, idle/accepting.
REQ-009 SHALL have ports: o_mem_rd out 1, read strobe; o_mem_addr0 and o_mem_addr1 out addr_width_p, upper/lower pixel addresses; i_mem_data0 and i_mem_data1 in 3*bpp_p, {R,G,B} pixels with R in the MSBs.
REQ-010 SHALL have ports: o_r0, o_g0, o_b0, o_r1, o_g1, o_b1 out 1, panel data; o_sclk out 1, shift clock; o_latch out 1, panel latch.

Function
REQ-011 SHALL implement states IDLE, FETCH, CAPTURE, SHIFT_LO, SHIFT_HI, WAIT_BLANK, LATCH.
REQ-012 SHALL drive o_tx_ready = 1 exactly when state is IDLE.
REQ-013 SHALL, in IDLE on i_tx_start=1, register i_init_addr, i_pix_bit and i_clk_div, clear the column counter, and enter FETCH next cycle.
REQ-014 SHALL ignore i_tx_start outside IDLE, with no effect on the current line or the captured values.
REQ-015 SHALL, in FETCH, assert o_mem_rd for exactly one cycle with o_mem_addr0 = init+col and o_mem_addr1 = init+col+frame_size_p/2, both modulo 2^addr_width_p, then enter CAPTURE.
REQ-016 SHALL treat memory data as valid the cycle after o_mem_rd (CAPTURE).
REQ-017 SHALL, in CAPTURE, register o_r0 = i_mem_data0[2*bpp_p+pix_bit], o_g0 = i_mem_data0[bpp_p+pix_bit] and o_b0 = i_mem_data0[pix_bit], and the same for segment 1 from i_mem_data1, then enter SHIFT_LO.
REQ-018 SHALL hold o_sclk=0 for D+1 cycles in SHIFT_LO, then o_sclk=1 for D+1 cycles in SHIFT_HI, using the captured D (D=0 gives 1-cycle phases).
REQ-019 SHALL keep o_r*/o_g*/o_b* stable from CAPTURE through the end of SHIFT_HI.
REQ-020 SHALL, at the end of SHIFT_HI, go to WAIT_BLANK if col = hpixel_p-1, else increment col and go to FETCH; per-pixel period is 2D+4 cycles.
REQ-021 SHALL hold o_sclk=0 in all states other than SHIFT_HI.
REQ-022 SHALL, in WAIT_BLANK, advance to LATCH when i_blanking=1 or i_timer_en=0 (level-sensitive), else remain.
REQ-023 SHALL assert o_latch for exactly the one LATCH cycle, then return to IDLE.
REQ-024 SHALL latch in the first WAIT_BLANK cycle when i_blanking and i_timer_en change in that same cycle and the condition evaluates true.
REQ-025 SHALL size the column counter to clog2(hpixel_p) bits and clear it on entering IDLE.

Reset
REQ-026 SHALL, on rst_n=0, asynchronously force state=IDLE, o_tx_ready=1, and o_mem_rd, o_mem_addr0/1, o_r*/o_g*/o_b*, o_sclk and o_latch to 0, with column counter and captured registers cleared.
REQ-027 SHALL abandon any line in progress when reset asserts mid-line, produce no o_latch, and accept a new i_tx_start on the first cycle after rst_n rises.

Verification
REQ-028 SHALL cover: D=0, init=0, pix_bit=0, pixel 0 = 0xFF_00_01 -> o_mem_rd at cycle 1 with addr0=0, addr1=2048; o_r0=1, o_g0=0, o_b0=1 at cycle 2; 64 sclk pulses; line length 256 cycles to WAIT_BLANK.
REQ-029 SHALL cover: D=3 -> sclk low 4 / high 4 cycles; 10 cycles per pixel; data stable across each pulse.
REQ-030 SHALL cover: i_timer_en=1, i_blanking=0 held 50 cycles after the last pixel -> no o_latch; i_blanking=1 -> one-cycle o_latch, o_tx_ready=1 the next cycle.
REQ-031 SHALL cover: i_timer_en=0 at line end -> o_latch one cycle after WAIT_BLANK entry with no blanking required.
REQ-032 SHALL cover: i_tx_start pulsed mid-line, and i_init_addr=4032 with pix_bit=7 -> the mid-line pulse is ignored; addr1 wraps to 1984; bit 7 of each channel is selected.
REQ-033 SHALL cover: rst_n low at pixel 30 -> all outputs 0 and o_tx_ready=1 immediately; no o_latch; a new line completes normally.

Source files
------------

// File: rtl/hub75_line_tx.sv
// ---------------------------------------------------------------------------
// hub75_line_tx
//   Shifts one row pair of a HUB75 panel out for a single bit plane. For each
//   column, the upper and lower segment pixels are fetched from frame memory,
//   the selected bit of each colour channel is presented on the panel data
//   pins, and one shift-clock pulse is produced whose low and high phases each
//   last D+1 cycles. After the last column the transmitter waits until the
//   panel is blanked (or the display timer is stopped) and then pulses the
//   latch for one cycle.
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   i_clk_div              : shift-clock phase length minus one (D)
//   i_tx_start             : start a line (honoured only while idle)
//   i_init_addr            : address of the first pixel of the upper row
//   i_pix_bit              : bit plane to transmit
//   i_blanking, i_timer_en : latch permission (blanked, or timer stopped)
//   o_tx_ready             : high while idle
//   o_mem_rd               : one-cycle read strobe; data returns next cycle
//   o_mem_addr0/1          : upper / lower segment pixel addresses
//   i_mem_data0/1          : {R,G,B} pixels, R in the MSBs
//   o_r0..o_b1             : panel colour data for both segments
//   o_sclk, o_latch        : panel shift clock and latch
// ---------------------------------------------------------------------------
module hub75_line_tx #(
  parameter int hpixel_p     = 64,
  parameter int vpixel_p     = 64,
  parameter int bpp_p        = 8,
  parameter int clk_div_wd_p = 8,
  localparam int frame_size_p    = hpixel_p * vpixel_p,
  localparam int addr_width_p    = $clog2(frame_size_p),
  localparam int pix_bit_width_p = $clog2(bpp_p)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [clk_div_wd_p-1:0]    i_clk_div,
  input  logic                       i_tx_start,
  input  logic [addr_width_p-1:0]    i_init_addr,
  input  logic [pix_bit_width_p-1:0] i_pix_bit,
  input  logic                       i_blanking,
  input  logic                       i_timer_en,
  output logic                       o_tx_ready,
  output logic                       o_mem_rd,
  output logic [addr_width_p-1:0]    o_mem_addr0,
  output logic [addr_width_p-1:0]    o_mem_addr1,
  input  logic [3*bpp_p-1:0]         i_mem_data0,
  input  logic [3*bpp_p-1:0]         i_mem_data1,
  output logic                       o_r0,
  output logic                       o_g0,
  output logic                       o_b0,
  output logic                       o_r1,
  output logic                       o_g1,
  output logic                       o_b1,
  output logic                       o_sclk,
  output logic                       o_latch
);

  localparam int col_width_p = $clog2(hpixel_p);
  localparam logic [col_width_p-1:0]  last_col_p   = col_width_p'(hpixel_p - 1);
  localparam logic [addr_width_p-1:0] half_frame_p = addr_width_p'(frame_size_p / 2);

  typedef enum logic [2:0] {
    IDLE, FETCH, CAPTURE, SHIFT_LO, SHIFT_HI, WAIT_BLANK, LATCH
  } state_t;

  state_t                      state_q;
  logic [col_width_p-1:0]      col_q;
  logic [addr_width_p-1:0]     init_q;
  logic [pix_bit_width_p-1:0]  pix_bit_q;
  logic [clk_div_wd_p-1:0]     div_q;
  logic [clk_div_wd_p-1:0]     div_cnt_q;
  logic                        tx_ready_q;
  logic                        mem_rd_q;
  logic [addr_width_p-1:0]     addr0_q;
  logic [addr_width_p-1:0]     addr1_q;
  logic                        r0_q, g0_q, b0_q, r1_q, g1_q, b1_q;
  logic                        sclk_q;
  logic                        latch_q;

  // Address of the pixel about to be fetched. When leaving IDLE the captured
  // base is not registered yet, so the raw input is used (column 0); when
  // leaving SHIFT_HI it is the next column of the captured base.
  logic [addr_width_p-1:0] addr0_d;
  logic [addr_width_p-1:0] addr1_d;

  always_comb begin
    addr0_d = init_q + addr_width_p'(col_q) + addr_width_p'(1);
    if (state_q == IDLE) begin
      addr0_d = i_init_addr;
    end
    // Lower segment is half a frame further on; wraps modulo the address space.
    addr1_d = addr0_d + half_frame_p;
  end

  // Per-channel slices, so the bit-plane select uses a natively sized index.
  logic [bpp_p-1:0] r0_ch, g0_ch, b0_ch, r1_ch, g1_ch, b1_ch;

  assign r0_ch = i_mem_data0[3*bpp_p-1:2*bpp_p];
  assign g0_ch = i_mem_data0[2*bpp_p-1:bpp_p];
  assign b0_ch = i_mem_data0[bpp_p-1:0];
  assign r1_ch = i_mem_data1[3*bpp_p-1:2*bpp_p];
  assign g1_ch = i_mem_data1[2*bpp_p-1:bpp_p];
  assign b1_ch = i_mem_data1[bpp_p-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      init_q     <= '0;
      pix_bit_q  <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      mem_rd_q   <= 1'b0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      r0_q       <= 1'b0;
      g0_q       <= 1'b0;
      b0_q       <= 1'b0;
      r1_q       <= 1'b0;
      g1_q       <= 1'b0;
      b1_q       <= 1'b0;
      sclk_q     <= 1'b0;
      latch_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_tx_start) begin
            init_q     <= i_init_addr;
            pix_bit_q  <= i_pix_bit;
            div_q      <= i_clk_div;
            col_q      <= '0;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            mem_rd_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            state_q    <= FETCH;
          end
        end

        FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= CAPTURE;
        end

        CAPTURE: begin
          // Memory data is valid now; these bits stay put until the next
          // CAPTURE, which keeps them stable across the whole sclk pulse.
          r0_q      <= r0_ch[pix_bit_q];
          g0_q      <= g0_ch[pix_bit_q];
          b0_q      <= b0_ch[pix_bit_q];
          r1_q      <= r1_ch[pix_bit_q];
          g1_q      <= g1_ch[pix_bit_q];
          b1_q      <= b1_ch[pix_bit_q];
          div_cnt_q <= '0;
          state_q   <= SHIFT_LO;
        end

        SHIFT_LO: begin
          if (div_cnt_q == div_q) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b1;
            state_q   <= SHIFT_HI;
          end else begin
            div_cnt_q <= div_cnt_q + clk_div_wd_p'(1);
          end
        end

        SHIFT_HI: begin
          if (div_cnt_q == div_q) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
            if (col_q == last_col_p) begin
              state_q <= WAIT_BLANK;
            end else begin
              col_q    <= col_q + col_width_p'(1);
              addr0_q  <= addr0_d;
              addr1_q  <= addr1_d;
              mem_rd_q <= 1'b1;
              state_q  <= FETCH;
            end
          end else begin
            div_cnt_q <= div_cnt_q + clk_div_wd_p'(1);
          end
        end

        WAIT_BLANK: begin
          // Latching while the panel is lit would show a half-updated row.
          if (i_blanking || !i_timer_en) begin
            latch_q <= 1'b1;
            state_q <= LATCH;
          end
        end

        LATCH: begin
          latch_q    <= 1'b0;
          tx_ready_q <= 1'b1;
          col_q      <= '0;
          state_q    <= IDLE;
        end

        default: begin
          mem_rd_q   <= 1'b0;
          sclk_q     <= 1'b0;
          latch_q    <= 1'b0;
          tx_ready_q <= 1'b1;
          col_q      <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready  = tx_ready_q;
  assign o_mem_rd    = mem_rd_q;
  assign o_mem_addr0 = addr0_q;
  assign o_mem_addr1 = addr1_q;
  assign o_r0        = r0_q;
  assign o_g0        = g0_q;
  assign o_b0        = b0_q;
  assign o_r1        = r1_q;
  assign o_g1        = g1_q;
  assign o_b1        = b1_q;
  assign o_sclk      = sclk_q;
  assign o_latch     = latch_q;

endmodule

// File: tb/tb_hub75_line_tx.sv
// ---------------------------------------------------------------------------
// tb_hub75_line_tx
//   Directed bench for hub75_line_tx with default parameters (64x64, 8 bpp).
//   A time-indexed line model predicts every output on every cycle; literal
//   checks pin key instants of the model.
// ---------------------------------------------------------------------------
module tb_hub75_line_tx;

  localparam int FRAME = 4096;
  localparam int HPIX  = 64;
  localparam int M_IDLE  = 0;
  localparam int M_LINE  = 1;
  localparam int M_WAIT  = 2;
  localparam int M_LATCH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  i_clk_div = '0;
  logic        i_tx_start = 1'b0;
  logic [11:0] i_init_addr = '0;
  logic [2:0]  i_pix_bit = '0;
  logic        i_blanking = 1'b0;
  logic        i_timer_en = 1'b1;
  logic        o_tx_ready;
  logic        o_mem_rd;
  logic [11:0] o_mem_addr0;
  logic [11:0] o_mem_addr1;
  logic [23:0] i_mem_data0 = '0;
  logic [23:0] i_mem_data1 = '0;
  logic        o_r0, o_g0, o_b0, o_r1, o_g1, o_b1;
  logic        o_sclk;
  logic        o_latch;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  logic [23:0] mem [FRAME];

  hub75_line_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clk_div   (i_clk_div),
    .i_tx_start  (i_tx_start),
    .i_init_addr (i_init_addr),
    .i_pix_bit   (i_pix_bit),
    .i_blanking  (i_blanking),
    .i_timer_en  (i_timer_en),
    .o_tx_ready  (o_tx_ready),
    .o_mem_rd    (o_mem_rd),
    .o_mem_addr0 (o_mem_addr0),
    .o_mem_addr1 (o_mem_addr1),
    .i_mem_data0 (i_mem_data0),
    .i_mem_data1 (i_mem_data1),
    .o_r0        (o_r0),
    .o_g0        (o_g0),
    .o_b0        (o_b0),
    .o_r1        (o_r1),
    .o_g1        (o_g1),
    .o_b1        (o_b1),
    .o_sclk      (o_sclk),
    .o_latch     (o_latch)
  );

  always #5 clk = ~clk;

  // Frame memory with one-cycle read latency.
  always @(posedge clk) begin
    if (o_mem_rd) begin
      i_mem_data0 <= mem[o_mem_addr0];
      i_mem_data1 <= mem[o_mem_addr1];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] px(input logic [23:0] d, input int b);
    logic [23:0] s;
    s = d >> b;
    return {s[16], s[8], s[0]};
  endfunction

  // ---------------- behavioural model ----------------
  // A line is a sequence of 64 pixel slots of P = 2D+4 cycles; slot cycle 0 is
  // the read, cycle 1 the capture, then D+1 cycles low and D+1 cycles high.
  int         m_mode = M_IDLE;
  int         m_t = 0;
  int         m_D = 0;
  int         m_init = 0;
  int         m_pb = 0;
  logic [5:0] m_rgb = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_t    = 0;
      m_rgb  = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (i_tx_start) begin
            m_D    = int'(i_clk_div);
            m_init = int'(i_init_addr);
            m_pb   = int'(i_pix_bit);
            m_t    = 1;
            m_mode = M_LINE;
          end
        end
        M_LINE: begin
          if ((m_t - 1) % (2*m_D + 4) == 1) begin
            int p;
            p = (m_t - 1) / (2*m_D + 4);
            m_rgb = {px(mem[(m_init + p) % FRAME], m_pb),
                     px(mem[(m_init + p + FRAME/2) % FRAME], m_pb)};
          end
          if (m_t == HPIX * (2*m_D + 4)) m_mode = M_WAIT;
          else m_t++;
        end
        M_WAIT:  if (i_blanking || !i_timer_en) m_mode = M_LATCH;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  int   c_P, c_ph, c_p;
  logic c_rd, c_sclk;

  always @(negedge clk) begin
    if (chk_en) begin
      c_P    = 2*m_D + 4;
      c_ph   = (m_t - 1) % c_P;
      c_p    = (m_t - 1) / c_P;
      c_rd   = (m_mode == M_LINE) && (c_ph == 0);
      c_sclk = (m_mode == M_LINE) && (c_ph >= m_D + 3);
      chk("tx_ready", 32'(o_tx_ready), 32'(m_mode == M_IDLE));
      chk("mem_rd",   32'(o_mem_rd),   32'(c_rd));
      chk("sclk",     32'(o_sclk),     32'(c_sclk));
      chk("latch",    32'(o_latch),    32'(m_mode == M_LATCH));
      chk("rgb", 32'({o_r0, o_g0, o_b0, o_r1, o_g1, o_b1}), 32'(m_rgb));
      if (c_rd) begin
        chk("addr0", 32'(o_mem_addr0), 32'((m_init + c_p) % FRAME));
        chk("addr1", 32'(o_mem_addr1), 32'((m_init + c_p + FRAME/2) % FRAME));
      end
      if (!rst_n) begin
        chk("rst_addr0", 32'(o_mem_addr0), 32'(0));
        chk("rst_addr1", 32'(o_mem_addr1), 32'(0));
      end
    end
  end

  task automatic start_line(input int d, input int a, input int pb);
    @(negedge clk);
    i_clk_div   = 8'(d);
    i_init_addr = 12'(a);
    i_pix_bit   = 3'(pb);
    i_tx_start  = 1'b1;
    @(negedge clk);
    i_tx_start  = 1'b0;
  endtask

  // Runs until o_latch is seen or the budget runs out; n = cycles waited.
  task automatic wait_latch(input int budget, output int n, output int pulses);
    logic prev;
    prev = o_sclk;
    n = 0;
    pulses = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      n++;
      if (o_sclk && !prev) pulses++;
      prev = o_sclk;
      if (o_latch) break;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n, pulses, lat_cnt;

  initial begin
    for (int i = 0; i < FRAME; i++) mem[i] = 24'((i * 32'h9E3779B1) >> 7);
    mem[0]    = 24'hFF0001;
    mem[2048] = 24'h00FF00;
    mem[4032] = 24'h807F80;
    mem[1984] = 24'h7F807F;

    // Reset state
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset_ready", 32'(o_tx_ready), 32'(1));
    chk("reset_rd",    32'(o_mem_rd),   32'(0));
    chk("reset_latch", 32'(o_latch),    32'(0));
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // D=0, init 0, plane 0, timer stopped: latch without blanking
    i_timer_en = 1'b0;
    start_line(0, 0, 0);
    chk("t1_rd",    32'(o_mem_rd),    32'(1));
    chk("t1_addr0", 32'(o_mem_addr0), 32'(0));
    chk("t1_addr1", 32'(o_mem_addr1), 32'(2048));
    repeat (2) @(negedge clk);
    chk("t1_rgb", 32'({o_r0, o_g0, o_b0, o_r1, o_g1, o_b1}), 32'(6'b101010));
    wait_latch(400, n, pulses);
    chk("t1_latch_cycle", 32'(n + 3), 32'(258));
    chk("t1_sclk_pulses", 32'(pulses), 32'(64));
    @(negedge clk);
    chk("t1_ready_after", 32'(o_tx_ready), 32'(1));
    i_timer_en = 1'b1;

    // D=3: 4 low / 4 high, 10 cycles per pixel; then wait for blanking
    start_line(3, 100, 3);
    repeat (5) @(negedge clk);
    chk("t2_sclk_t6",  32'(o_sclk), 32'(0));
    @(negedge clk);
    chk("t2_sclk_t7",  32'(o_sclk), 32'(1));
    repeat (3) @(negedge clk);
    chk("t2_sclk_t10", 32'(o_sclk), 32'(1));
    @(negedge clk);
    chk("t2_sclk_t11", 32'(o_sclk), 32'(0));
    chk("t2_rd_t11",   32'(o_mem_rd), 32'(1));
    chk("t2_addr_t11", 32'(o_mem_addr0), 32'(101));
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (m_mode == M_WAIT) break;
    end
    chk("t2_reach_wait", 32'(m_mode), 32'(M_WAIT));
    lat_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_latch) lat_cnt++;
    end
    chk("t2_no_latch", 32'(lat_cnt), 32'(0));
    i_blanking = 1'b1;
    @(negedge clk);
    chk("t2_latch", 32'(o_latch), 32'(1));
    i_blanking = 1'b0;
    @(negedge clk);
    chk("t2_ready", 32'(o_tx_ready), 32'(1));
    chk("t2_latch_off", 32'(o_latch), 32'(0));

    // Address wrap, plane 7, start pulse ignored mid-line
    start_line(1, 4032, 7);
    chk("t3_addr0", 32'(o_mem_addr0), 32'(4032));
    chk("t3_addr1", 32'(o_mem_addr1), 32'(1984));
    repeat (2) @(negedge clk);
    chk("t3_rgb", 32'({o_r0, o_g0, o_b0, o_r1, o_g1, o_b1}), 32'(6'b101010));
    repeat (40) @(negedge clk);
    i_tx_start = 1'b1;
    i_init_addr = 12'd5;
    i_pix_bit = 3'd2;
    i_clk_div = 8'd0;
    @(negedge clk);
    i_tx_start = 1'b0;
    i_blanking = 1'b1;
    wait_latch(800, n, pulses);
    chk("t3_latch_seen", 32'(o_latch), 32'(1));
    i_blanking = 1'b0;
    @(negedge clk);

    // Reset in the middle of pixel 30, then a fresh line
    start_line(0, 0, 0);
    repeat (122) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_ready", 32'(o_tx_ready), 32'(1));
    chk("t4_rd",    32'(o_mem_rd),   32'(0));
    chk("t4_sclk",  32'(o_sclk),     32'(0));
    chk("t4_latch", 32'(o_latch),    32'(0));
    chk("t4_rgb", 32'({o_r0, o_g0, o_b0, o_r1, o_g1, o_b1}), 32'(0));
    chk("t4_addr0", 32'(o_mem_addr0), 32'(0));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    i_clk_div = 8'd0;
    i_init_addr = 12'd64;
    i_pix_bit = 3'd1;
    i_tx_start = 1'b1;
    @(negedge clk);
    i_tx_start = 1'b0;
    chk("t4_restart_rd",   32'(o_mem_rd),    32'(1));
    chk("t4_restart_addr", 32'(o_mem_addr0), 32'(64));
    i_blanking = 1'b1;
    wait_latch(400, n, pulses);
    chk("t4_latch_cycle", 32'(n + 1), 32'(258));
    chk("t4_pulses", 32'(pulses), 32'(64));
    i_blanking = 1'b0;
    @(negedge clk);
    chk("t4_ready_end", 32'(o_tx_ready), 32'(1));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
